// File: rtl/if_stage_fetch_if.sv
// Fetch-stage bundle: I-cache read port, hazard/redirect controls and IF/ID outputs.
// The master modport is the fetch stage; the slave modport is the rest of the core.
interface if_stage_fetch_if;
    logic        hazard_stall;
    logic        hazard_flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_stall;
    logic        icache_ren;
    logic [29:0] icache_addr;
    logic        icache_stall;
    logic [31:0] icache_rdata;
    logic [31:0] IF_ID_pc;
    logic [31:0] IF_ID_inst;
    logic        IF_ID_valid;
    logic [6:0]  IF_ID_op;
    logic [4:0]  IF_ID_rs1;
    logic [4:0]  IF_ID_rs2;

    modport master (
        input  hazard_stall, hazard_flush, redirect_valid, redirect_pc, mem_stall,
        input  icache_stall, icache_rdata,
        output icache_ren, icache_addr,
        output IF_ID_pc, IF_ID_inst, IF_ID_valid, IF_ID_op, IF_ID_rs1, IF_ID_rs2
    );

    modport slave (
        output hazard_stall, hazard_flush, redirect_valid, redirect_pc, mem_stall,
        output icache_stall, icache_rdata,
        input  icache_ren, icache_addr,
        input  IF_ID_pc, IF_ID_inst, IF_ID_valid, IF_ID_op, IF_ID_rs1, IF_ID_rs2
    );
endinterface

// File: rtl/if_stage_fetch.sv
// RV32 instruction-fetch stage with IF/ID register. A redirect that lands while the
// I-cache is busy moves the FSM to DISCARD so the stale in-flight fetch is dropped.
module if_stage_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    if_stage_fetch_if.master  fe
);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        DISCARD = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_inst_q, ifid_inst_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        ren_q;

    logic [31:0] redir_tgt_s;
    logic [31:0] pc_inc_s;
    logic        bubble_s;
    logic        latch_s;

    assign redir_tgt_s = fe.redirect_pc & 32'hFFFF_FFFC;
    assign pc_inc_s    = pc_q + 32'd4;

    // Next-state selection for PC, pending target, FSM and IF/ID.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_d       = pend_q;
        bubble_s     = 1'b0;
        latch_s      = 1'b0;
        // No request was outstanding in the first cycle after reset, so nothing can return.
        if (fe.mem_stall || !ren_q) begin
            pc_d = pc_q;
        end else begin
            case (state_q)
                RUN: begin
                    if (fe.icache_stall) begin
                        if (fe.redirect_valid) begin
                            pend_d   = redir_tgt_s;
                            state_d  = DISCARD;
                            bubble_s = 1'b1;
                        end else begin
                            bubble_s = !fe.hazard_stall;
                        end
                    end else if (fe.redirect_valid) begin
                        pc_d     = redir_tgt_s;
                        bubble_s = 1'b1;
                    end else if (fe.hazard_stall) begin
                        pc_d = pc_q;
                    end else if (fe.hazard_flush) begin
                        pc_d     = pc_inc_s;
                        bubble_s = 1'b1;
                    end else begin
                        pc_d    = pc_inc_s;
                        latch_s = 1'b1;
                    end
                end
                DISCARD: begin
                    if (fe.redirect_valid) begin
                        pend_d = redir_tgt_s;
                    end else begin
                        pend_d = pend_q;
                    end
                    if (!fe.icache_stall) begin
                        pc_d     = fe.redirect_valid ? redir_tgt_s : pend_q;
                        bubble_s = 1'b1;
                        state_d  = RUN;
                    end else begin
                        bubble_s = !fe.hazard_stall;
                    end
                end
                default: begin
                    state_d  = RUN;
                    bubble_s = 1'b1;
                end
            endcase
        end

        if (bubble_s) begin
            ifid_pc_d    = 32'h0000_0000;
            ifid_inst_d  = NOP_INST;
            ifid_valid_d = 1'b0;
        end else if (latch_s) begin
            ifid_pc_d    = pc_q;
            ifid_inst_d  = fe.icache_rdata;
            ifid_valid_d = 1'b1;
        end else begin
            ifid_pc_d    = ifid_pc_q;
            ifid_inst_d  = ifid_inst_q;
            ifid_valid_d = ifid_valid_q;
        end
    end

    // State, PC and IF/ID registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            pc_q         <= RESET_PC;
            pend_q       <= 32'h0000_0000;
            ifid_pc_q    <= 32'h0000_0000;
            ifid_inst_q  <= NOP_INST;
            ifid_valid_q <= 1'b0;
            ren_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_inst_q  <= ifid_inst_d;
            ifid_valid_q <= ifid_valid_d;
            ren_q        <= 1'b1;
        end
    end

    assign fe.icache_ren  = ren_q;
    assign fe.icache_addr = pc_q[31:2];
    assign fe.IF_ID_pc    = ifid_pc_q;
    assign fe.IF_ID_inst  = ifid_inst_q;
    assign fe.IF_ID_valid = ifid_valid_q;
    assign fe.IF_ID_op    = ifid_inst_q[6:0];
    assign fe.IF_ID_rs1   = ifid_inst_q[19:15];
    assign fe.IF_ID_rs2   = ifid_inst_q[24:20];

endmodule

// File: tb/tb_if_stage_fetch.sv
// Directed bench for if_stage_fetch: the driver queues the hand-computed state expected
// after each edge; a monitor pops and compares just after every rising edge.
module tb_if_stage_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic [29:0] addr;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;
    exp_t exp_q[$];

    if_stage_fetch_if bus();

    if_stage_fetch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fe    (bus)
    );

    // I-cache model: the word at address A reads back as {A, 2'b11}.
    assign bus.icache_rdata = {bus.icache_addr, 2'b11};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_state(input string tag, input exp_t e);
        logic [31:0] ei;
        ei = e.valid ? (e.pc | 32'h0000_0003) : NOP;
        chk({tag, " IF_ID_pc"},    bus.IF_ID_pc,    e.pc);
        chk({tag, " IF_ID_inst"},  bus.IF_ID_inst,  ei);
        chk({tag, " IF_ID_valid"}, {31'd0, bus.IF_ID_valid}, {31'd0, e.valid});
        chk({tag, " icache_addr"}, {2'b00, bus.icache_addr}, {2'b00, e.addr});
        chk({tag, " icache_ren"},  {31'd0, bus.icache_ren},  32'd1);
        chk({tag, " decode"}, {15'd0, bus.IF_ID_op, bus.IF_ID_rs1, bus.IF_ID_rs2},
            {15'd0, ei[6:0], ei[19:15], ei[24:20]});
    endtask

    // Monitor: one expected snapshot per rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_state("cycle", e);
            end
        end
    end

    // Apply inputs for the coming edge and queue the state expected after it.
    task automatic cyc(input logic hs, input logic fl, input logic rv, input logic [31:0] rpc,
                       input logic ms, input logic is,
                       input logic [31:0] e_pc, input logic e_v, input logic [31:0] e_addr);
        exp_t e;
        bus.hazard_stall   = hs;
        bus.hazard_flush   = fl;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.mem_stall      = ms;
        bus.icache_stall   = is;
        e.pc    = e_pc;
        e.valid = e_v;
        e.addr  = e_addr[29:0];
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " ren"},   {31'd0, bus.icache_ren},  32'd0);
        chk({tag, " addr"},  {2'b00, bus.icache_addr}, 32'd0);
        chk({tag, " pc"},    bus.IF_ID_pc,   32'd0);
        chk({tag, " inst"},  bus.IF_ID_inst, NOP);
        chk({tag, " valid"}, {31'd0, bus.IF_ID_valid}, 32'd0);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        bus.hazard_stall   = 1'b0;
        bus.hazard_flush   = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        bus.mem_stall      = 1'b0;
        bus.icache_stall   = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;

        // Sequential fetch from reset: first edge only raises the request.
        cyc(0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
        for (int i = 1; i <= 8; i++) cyc(0, 0, 0, 0, 0, 0, 32'(4 * (i - 1)), 1, 32'(i));
        // Load-use stall at PC 0x20.
        cyc(1, 0, 0, 0, 0, 0, 32'h1C, 1, 32'h08);
        cyc(1, 0, 0, 0, 0, 0, 32'h1C, 1, 32'h08);
        cyc(0, 0, 0, 0, 0, 0, 32'h20, 1, 32'h09);
        for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 0, 0, 32'h24 + 32'(4 * i), 1, 32'h0A + 32'(i));
        // Misaligned redirect plus flush at PC 0x40.
        cyc(0, 1, 1, 32'h103, 0, 0, 32'h0, 0, 32'h40);
        cyc(0, 0, 0, 0, 0, 0, 32'h100, 1, 32'h41);
        // Redirect overrides hazard_stall.
        cyc(1, 0, 1, 32'h80, 0, 0, 32'h0, 0, 32'h20);
        // I-cache miss at 0x80 with redirect to 0x200 in its second cycle.
        cyc(0, 0, 0, 0, 0, 1, 32'h0, 0, 32'h20);
        cyc(0, 0, 1, 32'h200, 0, 1, 32'h0, 0, 32'h20);
        cyc(0, 0, 0, 0, 0, 1, 32'h0, 0, 32'h20);
        cyc(0, 0, 0, 0, 0, 1, 32'h0, 0, 32'h20);
        cyc(0, 0, 0, 0, 0, 1, 32'h0, 0, 32'h20);
        cyc(0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h80);
        cyc(0, 0, 0, 0, 0, 0, 32'h200, 1, 32'h81);
        // D-cache stall with redirect held high.
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 32'h300, 1, 0, 32'h200, 1, 32'h81);
        cyc(0, 0, 1, 32'h300, 0, 0, 32'h0, 0, 32'hC0);
        cyc(0, 0, 0, 0, 0, 0, 32'h300, 1, 32'hC1);
        // Flush alone, then hazard_stall holding IF/ID during a miss.
        cyc(0, 1, 0, 0, 0, 0, 32'h0, 0, 32'hC2);
        cyc(0, 0, 0, 0, 0, 0, 32'h308, 1, 32'hC3);
        cyc(1, 0, 0, 0, 0, 1, 32'h308, 1, 32'hC3);
        cyc(0, 0, 0, 0, 0, 1, 32'h0, 0, 32'hC3);
        // DISCARD: newest redirect wins, including one on the exit cycle.
        cyc(0, 0, 1, 32'h400, 0, 1, 32'h0, 0, 32'hC3);
        cyc(0, 0, 1, 32'h500, 0, 1, 32'h0, 0, 32'hC3);
        cyc(0, 0, 1, 32'h600, 0, 0, 32'h0, 0, 32'h180);
        cyc(0, 0, 0, 0, 0, 0, 32'h600, 1, 32'h181);
        // PC wrap at the top of the address space.
        cyc(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0, 0, 32'h3FFF_FFFF);
        cyc(0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 1, 32'h0);
        cyc(0, 0, 0, 0, 0, 0, 32'h0, 1, 32'h1);
        // Enter DISCARD, then reset asynchronously mid-miss.
        cyc(0, 0, 1, 32'h700, 0, 1, 32'h0, 0, 32'h1);
        #2;
        rst_n = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.icache_stall   = 1'b0;
        #1;
        check_reset("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
        cyc(0, 0, 0, 0, 0, 0, 32'h0, 1, 32'h1);
        cyc(0, 0, 0, 0, 0, 0, 32'h4, 1, 32'h2);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d expected snapshots unchecked, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/if_stage_fetch.md
Name: if_stage_fetch

Overview:
- Instruction-fetch stage and IF/ID pipeline register for the 5-stage RV32 core.
- Holds the PC and drives the I-cache read port.
- Latches the fetched instruction into IF/ID and supplies the decoded IF_ID_op/rs1/rs2 fields to the hazard detection unit.
- Consumes hazard_stall, hazard_flush and the branch/jump redirect. Tracks redirects that arrive while the I-cache is busy, so the stale fetch is discarded.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) placed in IF/ID.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- hazard_stall  in  1  hold PC and IF/ID (load-use).
- hazard_flush  in  1  replace IF/ID with bubble (ignored when hazard_stall=1).
- redirect_valid  in  1  taken branch / jal / jalr resolved this cycle.
- redirect_pc  in  32  redirect target.
- mem_stall  in  1  D-cache stall; freezes the whole stage.
- icache_ren  out  1  I-cache read request.
- icache_addr  out  30  word address = PC[31:2].
- icache_stall  in  1  I-cache busy; icache_rdata not valid.
- icache_rdata  in  32  fetched instruction, valid when icache_stall=0.
- IF_ID_pc  out  32  PC of instruction in IF/ID.
- IF_ID_inst  out  32  instruction in IF/ID.
- IF_ID_valid  out  1  IF/ID holds a real instruction.
- IF_ID_op  out  7  IF_ID_inst[6:0].
- IF_ID_rs1  out  5  IF_ID_inst[19:15].
- IF_ID_rs2  out  5  IF_ID_inst[24:20].

Behaviour:
- Reset (async, rst_n=0) sets:
  - PC=RESET_PC, state=RUN, pend_pc=0.
  - IF_ID_pc=0, IF_ID_inst=NOP_INST, IF_ID_valid=0.
  - icache_ren=0.
- After reset, icache_ren=1 continuously. icache_addr is always PC[31:2] and must stay stable while icache_stall=1.
- IF_ID_op, IF_ID_rs1 and IF_ID_rs2 are combinational slices of IF_ID_inst.
- Redirect targets are word-aligned: bits [1:0] are forced to 0.
- FSM states: RUN (normal), DISCARD (a redirect was accepted while the I-cache was busy; the in-flight fetch is stale).
- Evaluation order each rising edge, first match wins:
  1. mem_stall=1: PC, IF/ID, state and pend_pc all hold; redirect_valid ignored (EX is frozen and re-presents it).
  2. RUN, icache_stall=1:
     - PC holds.
     - If redirect_valid: pend_pc<=redirect_pc, state->DISCARD.
     - IF/ID: holds if hazard_stall=1 and redirect_valid=0; otherwise bubble.
  3. RUN, icache_stall=0, redirect_valid=1: PC<=redirect_pc; IF/ID<=bubble. Redirect overrides hazard_stall.
  4. RUN, icache_stall=0, hazard_stall=1: PC and IF/ID hold. Data re-fetched next cycle (same address).
  5. RUN, icache_stall=0, hazard_flush=1: PC<=PC+4; IF/ID<=bubble.
  6. RUN, normal: IF_ID_pc<=PC, IF_ID_inst<=icache_rdata, IF_ID_valid<=1; PC<=PC+4.
  7. DISCARD, redirect_valid=1: pend_pc<=redirect_pc (newest wins).
  8. DISCARD, icache_stall=0: returned data dropped; PC<=pend_pc (or redirect_pc if redirect_valid this cycle); IF/ID<=bubble; state->RUN.
  9. DISCARD, icache_stall=1: hold PC; IF/ID<=bubble unless hazard_stall=1 (hold).
- Bubble means IF_ID_inst=NOP_INST, IF_ID_valid=0, IF_ID_pc=0.
- PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- Latency: one cycle from icache_rdata valid to IF_ID_inst. Redirect-to-first-valid-IF/ID is 2 cycles with a cache hit.
- Reset asserted mid-miss returns to RUN immediately. The pending target is lost.

Test Plan:
1. Reset release, I-cache always hit, rdata=addr-based pattern:
   - icache_addr sequence is 0,1,2,...
   - IF_ID_pc is 0,4,8 on successive cycles; IF_ID_valid=1 from the 2nd edge.
2. PC=0x20 with hazard_stall=1 for 2 cycles:
   - IF_ID_pc stays 0x1C and icache_addr stays 0x08 for 2 cycles.
   - Then 0x20 enters IF/ID.
3. redirect_valid=1, redirect_pc=0x103, hazard_flush=1 at PC=0x40:
   - Next cycle IF_ID_valid=0 and icache_addr=0x40 (PC=0x100).
   - Following cycle IF_ID_pc=0x100.
4. icache_stall=1 for 5 cycles at PC=0x80, redirect to 0x200 in cycle 2:
   - Stale 0x80 data never reaches IF/ID (IF_ID_valid=0 throughout).
   - After stall drops, icache_addr=0x80 (PC=0x200).
5. mem_stall=1 for 3 cycles with redirect_valid held high:
   - All outputs frozen for 3 cycles.
   - Redirect takes effect on the first edge with mem_stall=0.
6. Assert rst_n=0 mid-miss in DISCARD:
   - Outputs return to reset values asynchronously (before the next edge).
   - After release, fetch restarts at RESET_PC.
